// File: rtl/ppu_bus_ctrl_if.sv
// CPU-side bus of the PPU controller: address/data strobes, read data and stall.
interface ppu_bus_ctrl_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic [7:0]  cpu_rdata;
    logic        cpu_stall;

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, cpu_re,
        input  cpu_rdata, cpu_stall
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
        output cpu_rdata, cpu_stall
    );
endinterface

// File: rtl/ppu_bus_ctrl.sv
// ppu_bus_ctrl: CPU<->PPU memory controller owning VRAM, palette RAM and OAM.
// Decodes the mirrored $2000-$2007 window; optional $4014 OAM DMA engine is
// built only when OAM_DMA_EN is defined (otherwise $4014 is ignored and the
// DMA outputs are tied low).
module ppu_bus_ctrl #(
    parameter int VRAM_AW = 11,
    parameter int OAM_AW  = 8,
    parameter int INC_BIG = 32
) (
    input  logic                clk,
    input  logic                rst,
    ppu_bus_ctrl_if.slave       bus,
    output logic [7:0]          ppu_ctrl,
    output logic [7:0]          ppu_mask,
    output logic [7:0]          scroll_x,
    output logic [7:0]          scroll_y,
    input  logic [7:0]          ppu_status,
    output logic                status_rd,
    output logic [15:0]         dma_addr,
    output logic                dma_re,
    input  logic [7:0]          dma_rdata,
    input  logic [13:0]         ppu_vaddr,
    output logic [7:0]          ppu_vdata,
    input  logic [OAM_AW-1:0]   ppu_oaddr,
    output logic [7:0]          ppu_odata
);

    logic [7:0] nt_mem  [2**VRAM_AW];
    logic [7:0] pal_mem [32];
    logic [7:0] oam_mem [2**OAM_AW];

    logic              w;
    logic [13:0]       v;
    logic [5:0]        t_hi;
    logic [7:0]        rbuf;
    logic [OAM_AW-1:0] oam_addr;
    logic [7:0]        rdata_q;
    logic              stall;

    // Palette entries $x10/$x14/$x18/$x1C share storage with $x00/$x04/$x08/$x0C.
    function automatic logic [4:0] pal_idx(input logic [13:0] a);
        pal_idx = (a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a[4:0];
    endfunction

    logic        win;
    logic [2:0]  rsel;
    logic        cpu_wr;
    logic        cpu_rd;
    logic        v_pal;
    logic [13:0] v_step;

    assign win    = (bus.cpu_addr[15:13] == 3'b001);
    assign rsel   = bus.cpu_addr[2:0];
    // A write wins over a simultaneous read; everything is ignored while stalled.
    assign cpu_wr = bus.cpu_we && !stall;
    assign cpu_rd = bus.cpu_re && !bus.cpu_we && !stall;
    assign v_pal  = (v >= 14'h3F00);
    assign v_step = ppu_ctrl[2] ? 14'(INC_BIG) : 14'd1;

    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_stall = stall;

    // Register file, write toggle, VRAM pointer, read buffer and read data latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            ppu_ctrl  <= 8'h00;
            ppu_mask  <= 8'h00;
            scroll_x  <= 8'h00;
            scroll_y  <= 8'h00;
            status_rd <= 1'b0;
            w         <= 1'b0;
            v         <= 14'h0000;
            t_hi      <= 6'h00;
            rbuf      <= 8'h00;
            oam_addr  <= '0;
            rdata_q   <= 8'h00;
        end else begin
            status_rd <= 1'b0;
            if (cpu_wr && win) begin
                case (rsel)
                    3'd0: ppu_ctrl <= bus.cpu_wdata;
                    3'd1: ppu_mask <= bus.cpu_wdata;
                    3'd3: oam_addr <= OAM_AW'(bus.cpu_wdata);
                    3'd4: oam_addr <= oam_addr + OAM_AW'(1);
                    3'd5: begin
                        if (w) scroll_y <= bus.cpu_wdata;
                        else   scroll_x <= bus.cpu_wdata;
                        w <= !w;
                    end
                    3'd6: begin
                        if (w) v    <= {t_hi, bus.cpu_wdata};
                        else   t_hi <= bus.cpu_wdata[5:0];
                        w <= !w;
                    end
                    3'd7: v <= v + v_step;
                    default: ;
                endcase
            end else if (cpu_rd && win) begin
                // Unlisted registers are write-only: rdata_q holds (open bus).
                case (rsel)
                    3'd2: begin
                        rdata_q   <= ppu_status;
                        w         <= 1'b0;
                        status_rd <= 1'b1;
                    end
                    3'd4: rdata_q <= oam_mem[oam_addr];
                    3'd7: begin
                        rdata_q <= v_pal ? pal_mem[pal_idx(v)] : rbuf;
                        rbuf    <= nt_mem[v[VRAM_AW-1:0]];
                        v       <= v + v_step;
                    end
                    default: ;
                endcase
            end
        end
    end

    logic              nt_we;
    logic              pal_we;
    logic              oam_we;
    logic [OAM_AW-1:0] oam_wa;
    logic [7:0]        oam_wd;

    assign nt_we  = !rst && cpu_wr && win && (rsel == 3'd7) && !v_pal;
    assign pal_we = !rst && cpu_wr && win && (rsel == 3'd7) && v_pal;

`ifdef OAM_DMA_EN
    typedef enum logic [1:0] {DMA_IDLE, DMA_RUN, DMA_DRAIN} dma_state_t;

    dma_state_t        dma_state;
    logic [7:0]        dma_page;
    logic [OAM_AW-1:0] dma_idx;
    logic              dma_wr_vld;
    logic [OAM_AW-1:0] dma_wr_k;

    // DMA sequencer: one read per cycle in RUN, DRAIN lands the last byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            dma_state  <= DMA_IDLE;
            dma_page   <= 8'h00;
            dma_idx    <= '0;
            dma_re     <= 1'b0;
            dma_addr   <= 16'h0000;
            dma_wr_vld <= 1'b0;
            dma_wr_k   <= '0;
            stall      <= 1'b0;
        end else begin
            dma_wr_vld <= dma_re;
            dma_wr_k   <= dma_idx;
            case (dma_state)
                DMA_IDLE: begin
                    if (cpu_wr && bus.cpu_addr == 16'h4014) begin
                        dma_state <= DMA_RUN;
                        dma_page  <= bus.cpu_wdata;
                        dma_idx   <= '0;
                        dma_addr  <= {bus.cpu_wdata, 8'h00};
                        dma_re    <= 1'b1;
                        stall     <= 1'b1;
                    end
                end
                DMA_RUN: begin
                    if (dma_idx == {OAM_AW{1'b1}}) begin
                        dma_state <= DMA_DRAIN;
                        dma_re    <= 1'b0;
                    end else begin
                        dma_idx  <= dma_idx + OAM_AW'(1);
                        dma_addr <= {dma_page, 8'h00} | 16'(dma_idx + OAM_AW'(1));
                    end
                end
                DMA_DRAIN: begin
                    dma_state <= DMA_IDLE;
                    stall     <= 1'b0;
                end
                default: dma_state <= DMA_IDLE;
            endcase
        end
    end

    // OAM write port: DMA data (relative to oam_addr) or CPU $2004 writes.
    always_comb begin
        oam_we = !rst && cpu_wr && win && (rsel == 3'd4);
        oam_wa = oam_addr;
        oam_wd = bus.cpu_wdata;
        if (dma_wr_vld) begin
            oam_we = !rst;
            oam_wa = oam_addr + dma_wr_k;
            oam_wd = dma_rdata;
        end
    end
`else
    logic unused_dma;

    assign stall      = 1'b0;
    assign dma_re     = 1'b0;
    assign dma_addr   = 16'h0000;
    assign unused_dma = ^dma_rdata;

    // OAM write port: CPU $2004 writes only.
    always_comb begin
        oam_we = !rst && cpu_wr && win && (rsel == 3'd4);
        oam_wa = oam_addr;
        oam_wd = bus.cpu_wdata;
    end
`endif

    // Nametable RAM write port.
    always_ff @(posedge clk) begin
        if (nt_we) nt_mem[v[VRAM_AW-1:0]] <= bus.cpu_wdata;
    end

    // Palette RAM write port.
    always_ff @(posedge clk) begin
        if (pal_we) pal_mem[pal_idx(v)] <= bus.cpu_wdata;
    end

    // OAM write port.
    always_ff @(posedge clk) begin
        if (oam_we) oam_mem[oam_wa] <= oam_wd;
    end

    // Render-side read ports: registered, independent of CPU traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            ppu_vdata <= 8'h00;
            ppu_odata <= 8'h00;
        end else begin
            ppu_vdata <= (ppu_vaddr >= 14'h3F00) ? pal_mem[pal_idx(ppu_vaddr)]
                                                 : nt_mem[ppu_vaddr[VRAM_AW-1:0]];
            ppu_odata <= oam_mem[ppu_oaddr];
        end
    end

endmodule

// File: tb/tb_ppu_bus_ctrl.sv
// Directed bench for ppu_bus_ctrl; DMA scenarios run when OAM_DMA_EN is defined,
// otherwise $4014 must be inert.
module tb_ppu_bus_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ppu_ctrl, ppu_mask, scroll_x, scroll_y;
    logic [7:0]  ppu_status = 8'h00;
    logic        status_rd;
    logic [15:0] dma_addr;
    logic        dma_re;
    logic [7:0]  dma_rdata = 8'h00;
    logic [13:0] ppu_vaddr = 14'h0000;
    logic [7:0]  ppu_vdata;
    logic [7:0]  ppu_oaddr = 8'h00;
    logic [7:0]  ppu_odata;

    int checks = 0;
    int errors = 0;

    ppu_bus_ctrl_if bus ();

    ppu_bus_ctrl #(.VRAM_AW(11), .OAM_AW(8), .INC_BIG(32)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ppu_ctrl(ppu_ctrl), .ppu_mask(ppu_mask),
        .scroll_x(scroll_x), .scroll_y(scroll_y),
        .ppu_status(ppu_status), .status_rd(status_rd),
        .dma_addr(dma_addr), .dma_re(dma_re), .dma_rdata(dma_rdata),
        .ppu_vaddr(ppu_vaddr), .ppu_vdata(ppu_vdata),
        .ppu_oaddr(ppu_oaddr), .ppu_odata(ppu_odata)
    );

    always #5 clk = ~clk;

    // CPU RAM model: page $02 holds i at offset i, other pages hold ~i.
    always @(posedge clk)
        if (dma_re) dma_rdata <= (dma_addr[15:8] == 8'h02) ? dma_addr[7:0] : ~dma_addr[7:0];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_we = 1'b1;
        @(negedge clk);
        bus.cpu_we = 1'b0;
    endtask

    task automatic cpu_rd(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.cpu_addr = a; bus.cpu_re = 1'b1;
        @(negedge clk);
        bus.cpu_re = 1'b0;
        d = bus.cpu_rdata;
    endtask

    task automatic vram_rd(input logic [13:0] a, output logic [7:0] d);
        @(negedge clk);
        ppu_vaddr = a;
        @(negedge clk);
        d = ppu_vdata;
    endtask

    task automatic oam_rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        ppu_oaddr = a;
        @(negedge clk);
        d = ppu_odata;
    endtask

    initial begin
        logic [7:0] d;
        int n;
        bus.cpu_addr = 16'h0000; bus.cpu_wdata = 8'h00;
        bus.cpu_we = 1'b0; bus.cpu_re = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_ctrl", ppu_ctrl, 8'h00);
        chk("rst_scroll", {scroll_x, scroll_y}, 16'h0000);
        chk("rst_rdata", bus.cpu_rdata, 8'h00);
        chk("rst_stall", bus.cpu_stall, 1'b0);
        chk("rst_status_rd", status_rd, 1'b0);

        // Buffered $2007 read
        cpu_wr(16'h2006, 8'h21); cpu_wr(16'h2006, 8'h08); cpu_wr(16'h2007, 8'h5A);
        cpu_wr(16'h2006, 8'h21); cpu_wr(16'h2006, 8'h08);
        cpu_rd(16'h2007, d); chk("rd2007_stale", d, 8'h00);
        cpu_rd(16'h2007, d); chk("rd2007_buf", d, 8'h5A);
        cpu_wr(16'h2007, 8'h77);
        vram_rd(14'h210A, d); chk("v_end_210A", d, 8'h77);
        vram_rd(14'h2108, d); chk("ppu_vram_2108", d, 8'h5A);

        // Increment 32 through a mirror of $2007
        cpu_wr(16'h2000, 8'h04);
        chk("ctrl_04", ppu_ctrl, 8'h04);
        cpu_wr(16'h2006, 8'h20); cpu_wr(16'h2006, 8'h00);
        cpu_wr(16'h200F, 8'h11); cpu_wr(16'h200F, 8'h22); cpu_wr(16'h200F, 8'h33);
        vram_rd(14'h2000, d); chk("inc32_2000", d, 8'h11);
        vram_rd(14'h2020, d); chk("inc32_2020", d, 8'h22);
        vram_rd(14'h2040, d); chk("inc32_2040", d, 8'h33);
        cpu_wr(16'h2000, 8'h00);

        // Shared toggle reset by $2002 read
        cpu_wr(16'h2005, 8'h10);
        ppu_status = 8'h80;
        cpu_rd(16'h2002, d);
        chk("status_data", d, 8'h80);
        chk("status_rd_pulse", status_rd, 1'b1);
        @(negedge clk);
        chk("status_rd_end", status_rd, 1'b0);
        cpu_wr(16'h2005, 8'h20); cpu_wr(16'h2005, 8'h30);
        chk("scroll_x", scroll_x, 8'h20);
        chk("scroll_y", scroll_y, 8'h30);

        // Palette mirror and unbuffered palette read
        cpu_wr(16'h2006, 8'h3F); cpu_wr(16'h2006, 8'h10); cpu_wr(16'h2007, 8'h0F);
        cpu_wr(16'h2006, 8'h3F); cpu_wr(16'h2006, 8'h00);
        cpu_rd(16'h2007, d); chk("pal_direct", d, 8'h0F);
        vram_rd(14'h3F10, d); chk("pal_alias_port", d, 8'h0F);

        // OAM access, no increment on read, open bus
        cpu_wr(16'h2003, 8'h04); cpu_wr(16'h2004, 8'hAB);
        cpu_wr(16'h2003, 8'h04);
        cpu_rd(16'h2004, d); chk("oam_rd", d, 8'hAB);
        cpu_rd(16'h2001, d); chk("open_bus", d, 8'hAB);
        cpu_wr(16'h2003, 8'hFF); cpu_wr(16'h2004, 8'hCD); cpu_wr(16'h2004, 8'hEF);
        oam_rd(8'hFF, d); chk("oam_ff", d, 8'hCD);
        oam_rd(8'h00, d); chk("oam_wrap", d, 8'hEF);

        // Write and read together: write wins, read ignored
        cpu_wr(16'h2003, 8'h20);
        @(negedge clk);
        bus.cpu_addr = 16'h2004; bus.cpu_wdata = 8'h5C; bus.cpu_we = 1'b1; bus.cpu_re = 1'b1;
        @(negedge clk);
        bus.cpu_we = 1'b0; bus.cpu_re = 1'b0;
        chk("we_re_rdata", bus.cpu_rdata, 8'hAB);
        oam_rd(8'h20, d); chk("we_re_write", d, 8'h5C);

`ifdef OAM_DMA_EN
        // Full DMA from page $02 at oam_addr $04
        cpu_wr(16'h2003, 8'h04);
        cpu_wr(16'h4014, 8'h02);
        chk("dma_addr0", dma_addr, 16'h0200);
        n = 0;
        while (bus.cpu_stall && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("dma_stall_len", 16'(n), 16'd257);
        oam_rd(8'h04, d); chk("dma_oam04", d, 8'h00);
        oam_rd(8'h03, d); chk("dma_oam03", d, 8'hFF);
        oam_rd(8'h05, d); chk("dma_oam05", d, 8'h01);
        cpu_rd(16'h2004, d); chk("dma_oam_addr", d, 8'h00);
`else
        cpu_wr(16'h4014, 8'h02);
        repeat (3) @(negedge clk);
        chk("nodma_stall", bus.cpu_stall, 1'b0);
        chk("nodma_re", dma_re, 1'b0);
`endif

        // Reset mid-activity clears all register outputs
        cpu_wr(16'h2000, 8'h80); cpu_wr(16'h2001, 8'h1E);
`ifdef OAM_DMA_EN
        cpu_wr(16'h4014, 8'h03);
        repeat (99) @(negedge clk);
        chk("dma_mid_stall", bus.cpu_stall, 1'b1);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_stall", bus.cpu_stall, 1'b0);
        chk("rst2_dma_re", dma_re, 1'b0);
        chk("rst2_ctrl_mask", {ppu_ctrl, ppu_mask}, 16'h0000);
        chk("rst2_scroll", {scroll_x, scroll_y}, 16'h0000);
        chk("rst2_rdata_vdata", {bus.cpu_rdata, ppu_vdata}, 16'h0000);
`ifdef OAM_DMA_EN
        repeat (3) @(negedge clk);
        chk("abort_stays_idle", bus.cpu_stall, 1'b0);
        oam_rd(8'h04, d); chk("abort_kept", d, 8'hFF);
        oam_rd(8'hFE, d); chk("abort_untouched", d, 8'hFA);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
